// File: rtl/solve_ntru_mul_acc_12_pkg.sv
// ============================================================================
// Module  : solve_ntru_mul_acc_12_pkg
// Brief   : Shared widths and limits for the NTRU product accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package solve_ntru_mul_acc_12_pkg;

    localparam int c_DIN_W     = 12;
    localparam int c_ACC_W     = 12;
    localparam int c_MAX_TERMS = 1024;
    localparam int c_CNT_W     = 11;

    // Packed result entry is {sum, count}.
    function automatic int entry_w(input int acc_w, input int cnt_w);
        return acc_w + cnt_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/solve_ntru_mul_acc_12_fifo2.sv
// ============================================================================
// Module  : solve_ntru_mul_acc_12_fifo2
// Brief   : Two-entry in-order synchronous FIFO holding finished group results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module solve_ntru_mul_acc_12_fifo2 #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/solve_ntru_mul_acc_12.sv
// ============================================================================
// Module  : solve_ntru_mul_acc_12
// Brief   : Accumulates signed multiplier products into wrapped group sums and
//           emits them through a 2-entry valid/ready buffer, stalling upstream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module solve_ntru_mul_acc_12
    import solve_ntru_mul_acc_12_pkg::*;
#(
    parameter int DIN_W     = c_DIN_W,
    parameter int ACC_W     = c_ACC_W,
    parameter int MAX_TERMS = c_MAX_TERMS,
    parameter int CNT_W     = c_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIN_W-1:0] din,
    input  logic             din_vld,
    input  logic             din_last,
    output logic             ce,
    output logic [ACC_W-1:0] m_data,
    output logic [CNT_W-1:0] m_cnt,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err_overrun
);

    localparam int ENTRY_W = entry_w(ACC_W, CNT_W);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   term_q, term_d;
    logic               err_q, err_d;
    logic [ACC_W-1:0]   din_ext;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               hit_max;
    logic               push;
    logic               pop;
    logic               buf_full;
    logic               buf_empty;
    logic [ENTRY_W-1:0] buf_dout;

    assign din_ext = ACC_W'(signed'(din));
    assign sum     = acc_q + din_ext;
    assign cnt     = term_q + CNT_W'(1);
    assign hit_max = (cnt == CNT_W'(MAX_TERMS));

    // ce depends only on buffer occupancy so m_ready never reaches upstream combinationally.
    assign ce     = !buf_full;
    assign accept = ce & din_vld;
    assign push   = accept & (din_last | hit_max);
    assign pop    = m_valid & m_ready;

    always_comb begin
        acc_d  = acc_q;
        term_d = term_q;
        err_d  = err_q;
        if (accept) begin
            if (push) begin
                acc_d  = '0;
                term_d = '0;
                if (!din_last) begin
                    err_d = 1'b1;
                end
            end else begin
                acc_d  = sum;
                term_d = cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            term_q <= '0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            term_q <= term_d;
            err_q  <= err_d;
        end
    end

    solve_ntru_mul_acc_12_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({sum, cnt}),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign m_valid     = !buf_empty;
    assign m_data      = buf_dout[ENTRY_W-1:CNT_W];
    assign m_cnt       = buf_dout[CNT_W-1:0];
    assign err_overrun = err_q;

endmodule

`default_nettype wire

// File: tb/tb_solve_ntru_mul_acc_12.sv
// ============================================================================
// Module  : tb_solve_ntru_mul_acc_12
// Brief   : Directed and random checks of the product accumulator against a
//           queue-based group model; a MAX_TERMS=4 copy exercises overrun.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_solve_ntru_mul_acc_12;

    typedef struct {
        int data;
        int cnt;
    } res_t;

    logic        clk;
    logic        reset;
    logic [11:0] din;
    logic        din_vld;
    logic        din_last;
    logic        m_ready;
    logic        ce;
    logic [11:0] m_data;
    logic [10:0] m_cnt;
    logic        m_valid;
    logic        err_overrun;
    logic        ce4;
    logic [11:0] m_data4;
    logic [2:0]  m_cnt4;
    logic        m_valid4;
    logic        err4;

    int   checks = 0;
    int   errors = 0;
    res_t pend[$];
    res_t q4[$];
    int   macc;
    int   mcnt;
    bit   merr;
    bit   got;

    solve_ntru_mul_acc_12 dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_vld     (din_vld),
        .din_last    (din_last),
        .ce          (ce),
        .m_data      (m_data),
        .m_cnt       (m_cnt),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .err_overrun (err_overrun)
    );

    solve_ntru_mul_acc_12 #(
        .MAX_TERMS (4),
        .CNT_W     (3)
    ) dut4 (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_vld     (din_vld),
        .din_last    (din_last),
        .ce          (ce4),
        .m_data      (m_data4),
        .m_cnt       (m_cnt4),
        .m_valid     (m_valid4),
        .m_ready     (m_ready),
        .err_overrun (err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle, then advance the model.
    task automatic step(input logic v, input logic l, input logic [11:0] d, input logic r,
                        output bit accepted);
        din      = d;
        din_vld  = v;
        din_last = l;
        m_ready  = r;
        @(negedge clk);
        chk("ce", {31'd0, ce}, {31'd0, pend.size() < 2});
        chk("m_valid", {31'd0, m_valid}, {31'd0, pend.size() != 0});
        if (pend.size() != 0) begin
            chk("m_data", {20'd0, m_data}, pend[0].data);
            chk("m_cnt", {21'd0, m_cnt}, pend[0].cnt);
        end
        chk("err_overrun", {31'd0, err_overrun}, {31'd0, merr});
        if (m_valid4 && r) q4.push_back('{int'(m_data4), int'(m_cnt4)});
        accepted = (pend.size() < 2) && v;
        if (pend.size() != 0 && r) void'(pend.pop_front());
        if (accepted) begin
            macc += int'($signed(d));
            mcnt++;
            if (l || mcnt == 1024) begin
                pend.push_back('{macc & 32'hFFF, mcnt});
                if (!l) merr = 1'b1;
                macc = 0;
                mcnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [11:0] d, input logic l, input logic r);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) step(1'b1, l, d, r, a);
        chk("offer_accepted", {31'd0, a}, 32'd1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'd0, 1'b1, a);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        din_vld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend.delete();
        q4.delete();
        macc = 0;
        mcnt = 0;
        merr = 1'b0;
    endtask

    initial begin
        bit a;
        clk      = 1'b0;
        reset    = 1'b1;
        din      = '0;
        din_vld  = 1'b0;
        din_last = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_ce", {31'd0, ce}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {20'd0, m_data}, 32'd0);
        chk("rst_m_cnt", {21'd0, m_cnt}, 32'd0);
        chk("rst_err", {31'd0, err_overrun}, 32'd0);
        @(posedge clk);
        #1;

        // Group of three with a negative term.
        offer(12'd5, 1'b0, 1'b1);
        offer(12'hFFD, 1'b0, 1'b1);
        offer(12'd7, 1'b1, 1'b1);
        idle(3);

        // Two's-complement wrap.
        offer(12'h7FF, 1'b0, 1'b1);
        offer(12'h001, 1'b1, 1'b1);
        idle(2);

        // Backpressure: buffer fills, third input held off until m_ready rises.
        offer(12'd1, 1'b1, 1'b0);
        offer(12'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 12'd3, 1'b0, a);
            chk("held_not_taken", {31'd0, a}, 32'd0);
        end
        offer(12'd3, 1'b1, 1'b1);
        offer(12'd4, 1'b1, 1'b1);
        idle(4);

        // Overrun on the MAX_TERMS=4 copy: six ones, then a zero closing the group.
        do_reset();
        for (int i = 0; i < 6; i++) offer(12'd1, 1'b0, 1'b1);
        offer(12'd0, 1'b1, 1'b1);
        idle(3);
        chk("ovr_results", q4.size(), 32'd2);
        if (q4.size() >= 2) begin
            chk("ovr_data0", q4[0].data, 32'd4);
            chk("ovr_cnt0", q4[0].cnt, 32'd4);
            chk("ovr_data1", q4[1].data, 32'd2);
            chk("ovr_cnt1", q4[1].cnt, 32'd3);
        end
        chk("ovr_err4", {31'd0, err4}, 32'd1);

        // Bubbles between valid terms.
        step(1'b1, 1'b0, 12'd2, 1'b1, a);
        step(1'b0, 1'b0, 12'd2, 1'b1, a);
        step(1'b1, 1'b0, 12'd2, 1'b1, a);
        step(1'b0, 1'b0, 12'd2, 1'b1, a);
        step(1'b1, 1'b1, 12'd2, 1'b1, a);
        idle(2);

        // Reset mid-group with one result buffered.
        offer(12'd3, 1'b1, 1'b0);
        offer(12'd1, 1'b0, 1'b0);
        offer(12'd1, 1'b0, 1'b0);
        do_reset();
        idle(1);
        offer(12'd10, 1'b1, 1'b1);
        idle(2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 4) == 0, 12'($urandom),
                 ($urandom % 4) != 0, a);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
